mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter peripheral on the NBBPU MMIO bus, the serial-output counterpart to the SoC's serial ADC input path. The CPU writes bytes to a data register; they are buffered in a small FIFO and shifted out 8N1, LSB first, on `tx`. A registered, address-qualified read port returns status. It drives zero when not selected, so its output can be OR-ed onto the shared read bus without bus conflict.

## Interface
- `CLKS_PER_BIT`, 104, clock cycles per UART bit (12 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 8, byte entries; power of two, 2..64.
- `BASE`, 16'h8020, base address; DATA = BASE, STATUS = BASE+1.
- `clock  input  1  system clock; all state changes on its rising edge.`
- `reset  input  1  asynchronous, active-low reset.`
- `address  input  16  CPU data address.`
- `write_enable  input  1  CPU store strobe, one cycle per store.`
- `write_data  input  16  store data; only [7:0] used.`
- `read_enable  input  1  CPU load strobe.`
- `read_data  output  16  registered status word; 16'h0000 when not selected.`
- `read_valid  output  1  high for one cycle when read_data carries STATUS.`
- `tx  output  1  UART serial line, idle high.`
- `busy  output  1  high while the FIFO is non-empty or a frame is in progress.`

## Operation
- Reset values (`reset` low, asynchronous): tx=1, busy=0, read_data=0, read_valid=0, FIFO empty, overflow=0, FSM=IDLE, baud counter=0.
- DATA write (write_enable=1, address=BASE):
  - If not full, push write_data[7:0].
  - If full, drop the byte and set sticky overflow.
  - Full is evaluated before any same-cycle pop, so a push while full is rejected even if a pop occurs that cycle.
- Writes to other addresses, including BASE+1, are ignored.
- STATUS read (read_enable=1, address=BASE+1): next cycle read_data = {8'h00, count[7:0] zero-extended... no: {11'b0, overflow, full, empty, busy, tx_active}.
  - tx_active = FSM≠IDLE.
  - Reading STATUS clears overflow on the same edge that captures it; the captured value shows 1.
  - Any other cycle: read_data=0, read_valid=0.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop head into shift register, go to START, drive tx=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=bit0.
  - DATA: each bit lasts CLKS_PER_BIT cycles; shift right. After bit7 completes, go to STOP with tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At end, if FIFO non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter loads CLKS_PER_BIT-1 on every state or bit entry and counts down; the bit ends on the cycle it reads 0. It is wide enough for 16 bits.
- FIFO: circular buffer with wrap-around read/write pointers; count has range 0..FIFO_DEPTH; empty when count=0, full when count=FIFO_DEPTH.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- busy = (FSM≠IDLE) | ~empty.
- Reset mid-frame: tx returns high immediately, FIFO flushed, partial frame abandoned.

## Timing
- tx, read_data, read_valid and busy are all registered; there are no combinational paths from inputs to outputs.
- Write to tx: store sampled at edge N → FIFO non-empty and busy=1 after N → pop at N+1 → tx falls after edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous, giving 10·CLKS_PER_BIT cycles per byte.
- Read latency is one cycle: read_enable at edge N → read_valid and read_data after edge N, for one cycle.
- busy falls on the edge that ends the last STOP bit when the FIFO is empty.
- Throughput: one store per cycle accepted until full; draining is one byte per frame.

## Test plan
- **Reset:** assert reset mid-frame (CLKS_PER_BIT=4) → tx=1, busy=0, read_data=0 immediately; after release, STATUS reads 16'h0004 (empty only).
- **Single byte 8'hA5 (CLKS_PER_BIT=4):** tx falls after the second edge following the store. Line sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. busy drops after 40 cycles of frame.
- **Back-to-back bytes 8'h00 then 8'hFF:** second start bit begins immediately after the first stop bit, with no extra idle cycle; total 80 cycles.
- **Overflow (FIFO_DEPTH=8):** 10 consecutive stores while idle → 9 bytes transmitted (1 popped early plus 8 buffered), last store dropped.
  - STATUS shows overflow=1 on the first read and 0 on the second read.
- **Simultaneous push and pop at full:** store arrives on the same edge STOP ends with FIFO full → byte dropped, overflow=1, count goes to FIFO_DEPTH-1.
- **Address decode:** read at BASE+2 and write to BASE+1 → read_data=0, read_valid=0, FIFO unchanged. Read of BASE+1 → read_valid for exactly one cycle.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// DATA (BASE) accepts bytes, STATUS (BASE+1) returns
// {11'b0, overflow, full, empty, busy, tx_active} one cycle after the load.
// read_data is zero whenever STATUS is not being returned, so it can be
// OR-ed onto a shared read bus.
module mmio_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [15:0] BASE         = 16'h8020
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic        write_enable,
   input  logic [15:0] write_data,
   input  logic        read_enable,
   output logic [15:0] read_data,
   output logic        read_valid,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned  PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [15:0]  STATUS_ADDR = BASE + 16'd1;
   localparam logic [15:0]  BAUD_LOAD   = 16'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0] DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_next;
   logic [15:0]      baud, baud_next;
   logic [2:0]       bit_idx, bit_next;
   logic [7:0]       shift, shift_next;
   logic             tx_next;
   logic             pop;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W:0]   count, count_next;
   logic             overflow;
   logic             empty, full, push, data_wr, status_rd, tx_active;
   logic             unused_hi;

   // Only the low byte of a store is transmitted.
   assign unused_hi = ^write_data[15:8];

   assign data_wr    = write_enable && (address == BASE);
   assign status_rd  = read_enable && (address == STATUS_ADDR);
   assign empty      = (count == '0);
   assign full       = (count == DEPTH_C);
   // Full is judged before any same-cycle pop: a store into a full FIFO is
   // dropped even if the transmitter frees a slot on the same edge.
   assign push       = data_wr && !full;
   assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
   assign tx_active  = (state != IDLE);

   // Frame sequencer: next state, baud reload/countdown, shift and line level.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would infer a latch.
      state_next = state;
      baud_next  = baud;
      bit_next   = bit_idx;
      shift_next = shift;
      tx_next    = tx;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr];
               state_next = START;
               tx_next    = 1'b0;
               baud_next  = BAUD_LOAD;
            end
         end
         START: begin
            if (baud == 16'd0) begin
               state_next = DATA;
               tx_next    = shift[0];
               bit_next   = 3'd0;
               baud_next  = BAUD_LOAD;
            end else begin
               baud_next = baud - 16'd1;
            end
         end
         DATA: begin
            if (baud == 16'd0) begin
               baud_next = BAUD_LOAD;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next   = bit_idx + 3'd1;
                  shift_next = shift >> 1;
                  tx_next    = shift[1];
               end
            end else begin
               baud_next = baud - 16'd1;
            end
         end
         STOP: begin
            if (baud == 16'd0) begin
               if (!empty) begin
                  // Chain straight into the next start bit: no idle gap.
                  pop        = 1'b1;
                  shift_next = mem[rd_ptr];
                  state_next = START;
                  tx_next    = 1'b0;
                  baud_next  = BAUD_LOAD;
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end else begin
               baud_next = baud - 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Sequencer registers; busy is registered from the post-edge view.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         state   <= IDLE;
         baud    <= 16'd0;
         bit_idx <= 3'd0;
         shift   <= 8'h00;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         baud    <= baud_next;
         bit_idx <= bit_next;
         shift   <= shift_next;
         tx      <= tx_next;
         busy    <= (state_next != IDLE) || (count_next != '0);
      end
   end

   // FIFO storage.
   always_ff @(posedge clock) begin
      // NOTE: the data array has no reset; validity is tracked by the reset
      // pointers and count, so clearing storage would only add logic.
      if (push) mem[wr_ptr] <= write_data[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         // A dropped store wins over a clearing STATUS read so the event
         // cannot be lost; the two cannot target one address in one cycle.
         if (data_wr && full) overflow <= 1'b1;
         else if (status_rd)  overflow <= 1'b0;
      end
   end

   // Registered read port: STATUS for one cycle, zero otherwise.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         read_data  <= 16'h0000;
         read_valid <= 1'b0;
      end else begin
         read_valid <= status_rd;
         read_data  <= status_rd ? {11'b0, overflow, full, empty, tx_active || !empty, tx_active}
                                 : 16'h0000;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed bench for mmio_uart_tx with a
// frame-position reference model and an independent serial receiver.
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 8;
   localparam logic [15:0] BASE  = 16'h8020;
   localparam int          FRAME = 10 * CPB;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = 16'h0000;
   logic        write_enable = 1'b0;
   logic [15:0] write_data = 16'h0000;
   logic        read_enable = 1'b0;
   logic [15:0] read_data;
   logic        read_valid;
   logic        tx;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE(BASE)) dut (
      .clock(clock), .reset(reset), .address(address),
      .write_enable(write_enable), .write_data(write_data),
      .read_enable(read_enable), .read_data(read_data),
      .read_valid(read_valid), .tx(tx), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A frame is a position 0..FRAME-1 counted in cycles since its start edge;
   // the line level follows from position / CPB.
   logic [7:0]  m_q[$];
   logic [7:0]  sent_q[$];
   int          m_pos = -1;
   logic [7:0]  m_cur = 8'h00;
   logic        m_ovf = 1'b0;
   logic        m_rv = 1'b0;
   logic [15:0] m_rd = 16'h0000;
   logic        m_wr, m_rdsel, m_full, m_empty, m_busy_pre, m_active;

   task automatic model_step();
      m_wr       = write_enable && (address == BASE);
      m_rdsel    = read_enable && (address == BASE + 16'd1);
      m_full     = (m_q.size() == DEPTH);
      m_empty    = (m_q.size() == 0);
      m_active   = (m_pos >= 0);
      m_busy_pre = m_active || !m_empty;
      m_rv = m_rdsel;
      m_rd = m_rdsel ? {11'b0, m_ovf, m_full, m_empty, m_busy_pre, m_active} : 16'h0000;
      if (m_pos >= 0) begin
         m_pos++;
         if (m_pos == FRAME) m_pos = -1;
      end
      if (m_pos < 0 && m_q.size() != 0) begin
         m_cur = m_q.pop_front();
         sent_q.push_back(m_cur);
         m_pos = 0;
      end
      if (m_wr && !m_full) m_q.push_back(write_data[7:0]);
      m_ovf = (m_ovf && !m_rdsel) || (m_wr && m_full);
   endtask

   function automatic logic exp_tx();
      int b;
      if (m_pos < 0) return 1'b1;
      b = m_pos / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   initial forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
         m_q.delete();
         m_pos = -1;
         m_ovf = 1'b0;
         m_rv  = 1'b0;
         m_rd  = 16'h0000;
      end else begin
         model_step();
      end
   end

   // Compare every output against the model once per cycle.
   initial forever begin
      @(negedge clock);
      if (chk_en) begin
         check("tx", tx, exp_tx());
         check("busy", busy, (m_pos >= 0) || (m_q.size() != 0));
         check("read_valid", read_valid, m_rv);
         check("read_data", read_data, m_rd);
      end
   end

   // ---------------- serial receiver ----------------
   logic       rx_on = 1'b0;
   int         rx_t = 0;
   logic [7:0] rx_sh = 8'h00;
   logic [7:0] rx_q[$];

   initial forever begin
      @(negedge clock);
      if (!reset) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (chk_en && tx == 1'b0) begin
            rx_on = 1'b1;
            rx_t  = 0;
         end
      end else begin
         rx_t++;
         if (rx_t % CPB == CPB / 2) begin
            if (rx_t / CPB == 0) check("rx_start_bit", tx, 1'b0);
            else if (rx_t / CPB <= 8) rx_sh[rx_t/CPB - 1] = tx;
            else begin
               check("rx_stop_bit", tx, 1'b1);
               rx_q.push_back(rx_sh);
               rx_on = 1'b0;
            end
         end
      end
   end

   // ---------------- drivers (called at a falling edge) ----------------
   task automatic store(input logic [15:0] addr, input logic [7:0] d);
      write_enable = 1'b1;
      address      = addr;
      write_data   = {8'($urandom), d};
      @(negedge clock);
      write_enable = 1'b0;
      address      = 16'h0000;
   endtask

   task automatic load(input logic [15:0] addr);
      read_enable = 1'b1;
      address     = addr;
      @(negedge clock);
      read_enable = 1'b0;
      address     = 16'h0000;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 2000) check("wait_idle_timeout", busy, 1'b0);
      repeat (2) @(negedge clock);
   endtask

   task automatic clear_q();
      rx_q.delete();
      sent_q.delete();
   endtask

   task automatic check_rx_vs_model(input string name);
      check({name, "_count"}, rx_q.size(), sent_q.size());
      for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
         check({name, "_byte"}, rx_q[i], sent_q[i]);
   endtask

   int a5_line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, thr;
      #2 reset = 1'b0;
      repeat (3) @(negedge clock);
      reset  = 1'b1;
      chk_en = 1'b1;
      @(negedge clock);

      // Reset state
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      load(BASE + 16'd1);
      check("rst_status", read_data, 16'h0004);
      check("rst_status_valid", read_valid, 1'b1);

      // Single byte A5
      clear_q();
      store(BASE, 8'hA5);
      check("a5_tx_before_pop", tx, 1'b1);
      check("a5_busy_after_store", busy, 1'b1);
      @(negedge clock);
      for (int c = 0; c < FRAME; c++) begin
         check("a5_line", tx, a5_line[c / CPB]);
         if (c == FRAME - 1) check("a5_busy_last", busy, 1'b1);
         @(negedge clock);
      end
      check("a5_busy_end", busy, 1'b0);
      check("a5_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("a5_rx_byte", rx_q[0], 8'hA5);

      // Back-to-back 00, FF
      wait_idle();
      clear_q();
      store(BASE, 8'h00);
      store(BASE, 8'hFF);
      for (int c = 0; c <= 2 * FRAME; c++) begin
         if (c == 0) check("b2b_first_start", tx, 1'b0);
         if (c == FRAME - 1) check("b2b_stop", tx, 1'b1);
         if (c == FRAME) check("b2b_second_start", tx, 1'b0);
         if (c == 2 * FRAME - 1) check("b2b_busy_last", busy, 1'b1);
         if (c == 2 * FRAME) check("b2b_busy_end", busy, 1'b0);
         if (c < 2 * FRAME) @(negedge clock);
      end
      check("b2b_rx_count", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         check("b2b_rx0", rx_q[0], 8'h00);
         check("b2b_rx1", rx_q[1], 8'hFF);
      end

      // Overflow: ten stores while idle
      wait_idle();
      clear_q();
      for (int i = 0; i < 10; i++) store(BASE, 8'(8'h10 + i));
      load(BASE + 16'd1);
      check("ovf_status_first", read_data, 16'h001B);
      load(BASE + 16'd1);
      check("ovf_status_second", read_data, 16'h000B);
      wait_idle();
      check("ovf_rx_count", rx_q.size(), 9);
      for (int i = 0; i < rx_q.size() && i < 9; i++) check("ovf_rx_byte", rx_q[i], 8'(8'h10 + i));

      // Store on the edge that ends STOP while full
      wait_idle();
      clear_q();
      for (int i = 0; i < 9; i++) store(BASE, 8'(8'h20 + i));
      repeat (FRAME - 8) @(negedge clock);
      store(BASE, 8'hEE);
      load(BASE + 16'd1);
      check("popfull_status", read_data, 16'h0013);
      store(BASE, 8'h30);
      load(BASE + 16'd1);
      check("popfull_refill_status", read_data, 16'h000B);
      wait_idle();
      check("popfull_rx_count", rx_q.size(), 10);
      for (int i = 0; i < rx_q.size() && i < 9; i++) check("popfull_rx_byte", rx_q[i], 8'(8'h20 + i));
      if (rx_q.size() == 10) check("popfull_rx_last", rx_q[9], 8'h30);

      // Address decode
      wait_idle();
      clear_q();
      load(BASE + 16'd2);
      check("dec_other_valid", read_valid, 1'b0);
      check("dec_other_data", read_data, 16'h0000);
      store(BASE + 16'd1, 8'h55);
      check("dec_status_write_busy", busy, 1'b0);
      @(negedge clock);
      check("dec_status_write_tx", tx, 1'b1);
      load(BASE + 16'd1);
      check("dec_status_valid", read_valid, 1'b1);
      check("dec_status_data", read_data, 16'h0004);
      @(negedge clock);
      check("dec_valid_one_cycle", read_valid, 1'b0);
      check("dec_data_cleared", read_data, 16'h0000);

      // Reset mid-frame
      store(BASE, 8'h3C);
      repeat (10) @(negedge clock);
      load(BASE + 16'd1);
      #1 reset = 1'b0;
      #1;
      check("rstmid_tx", tx, 1'b1);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_read_data", read_data, 16'h0000);
      check("rstmid_read_valid", read_valid, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      load(BASE + 16'd1);
      check("rstmid_status", read_data, 16'h0004);
      clear_q();

      // Randomized traffic: a heavy burst then light traffic
      for (int cyc = 0; cyc < 2000; cyc++) begin
         r   = int'($urandom_range(0, 99));
         thr = (cyc < 400) ? 40 : 4;
         if (r < thr) store(BASE, 8'($urandom));
         else if (r < thr + 8) load(BASE + 16'd1);
         else if (r < thr + 10) store(BASE + 16'd1, 8'($urandom));
         else if (r < thr + 12) load(16'($urandom_range(32'h8000, 32'h8040)));
         else if (r < thr + 13) store(16'($urandom_range(32'h8000, 32'h8040)), 8'($urandom));
         else @(negedge clock);
      end
      wait_idle();
      check_rx_vs_model("rand_rx");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
